mseq_gen_ch: RTL
================

// Module: mseq_gen_ch
// PURPOSE
//  Parametrised m-sequence (PN) chip generator, successor to the fixed 8-bit divided-enable LFSR.
//  Adds: generic width/polynomial/divider, run/stop FSM with clean chip-boundary stop, runtime seed load
//  with zero-seed protection, period-wrap strobe, chip-history capture and optional Manchester line output.
//  Sits between the system clock domain and the line driver / BER checker in the m_group test path.
// PARAMETERS
//  W     8        LFSR width, 2..32
//  POLY  9'h11D   feedback polynomial, W+1 bits incl. x^W and x^0 terms; Galois right-shift taps = POLY>>1
//  SEED  1        reset/fallback state, W bits, must be nonzero
//  DIV   6        clk cycles per chip; even, >=2
//  CAP   8        chip-history capture width, 1..32
// PORTS
//  clk        in   1    system clock, all logic on posedge
//  nCR        in   1    synchronous active-low reset
//  run        in   1    level: 1 = generate chips, 0 = stop at next chip boundary
//  seed_ld    in   1    one-cycle pulse: load seed_in into LFSR
//  seed_in    in   W    seed value
//  man_en     in   1    1 = m_man is Manchester coded, 0 = m_man = NRZ m
//  m          out  1    current chip (sreg[0])
//  m_man      out  1    line output
//  bit_stb    out  1    one-cycle pulse on last clk of each chip (LFSR advances on this edge)
//  frame_stb  out  1    pulse with bit_stb when the advanced state equals the last loaded seed
//  sreg       out  W    LFSR state
//  cap        out  CAP  last CAP retired chips, newest in bit 0
//  seed_err   out  1    sticky: a zero seed_in was rejected
// BEHAVIOUR
//  Reset (nCR=0 at posedge): sreg=SEED, seed_reg=SEED, cnt=0, state=IDLE, cap=0, seed_err=0;
//   hence m=SEED[0], bit_stb=0, frame_stb=0, m_man=0. Reset wins over every other input.
//  FSM (registered): IDLE -run=1-> RUN; RUN -run=0-> DRAIN; DRAIN -bit_stb-> IDLE; DRAIN -run=1-> RUN.
//   A chip already started is never truncated; IDLE holds cnt=0 and sreg.
//  Divider: cnt 0..DIV-1 in RUN/DRAIN, wraps to 0. bit_stb = (state!=IDLE) && (cnt==DIV-1), combinational.
//  LFSR step on bit_stb: sreg <= sreg[0] ? (sreg>>1)^(POLY>>1) : sreg>>1; cap <= {cap[CAP-2:0], sreg[0]}.
//  frame_stb = bit_stb && (next_sreg == seed_reg); primitive POLY => period 2^W-1 (255 for defaults).
//  seed_ld (priority over step, same cycle): seed_in!=0 -> sreg=seed_reg=seed_in; seed_in==0 -> sreg=seed_reg=SEED,
//   seed_err<=1. Always cnt<=0, cap unchanged; DRAIN->IDLE, RUN stays RUN (new chip starts next cycle), no bit_stb that cycle.
//  Manchester: half = (cnt >= DIV/2). man_en=1: m_man = half ? m : ~m (1 = low->high mid-chip); man_en=0: m_man=m.
//   m_man=0 whenever state==IDLE. man_en change takes effect immediately (caller changes it only in IDLE).
//  Widths: cnt is $clog2(DIV) bits; no arithmetic beyond cnt+1; all compares unsigned.
// STRUCTURE
//  Include m_seq_defs.vh: FSM state localparams (IDLE=0,RUN=1,DRAIN=2) and standard POLY constants
//   (POLY8=9'h11D, POLY12, POLY16) shared with the BER checker.
//  One sub-module: lfsr_core #(W,POLY) - combinational next-state function (sreg -> next_sreg); top owns registers,
//   so frame_stb compare and step share one next_sreg.
//  Top: divider, FSM, seed/err logic, capture shifter, Manchester mux; 2-3 always blocks.
// TESTING
//  1 Defaults, reset then run=1 for 4 chips -> m seq 1,0,1,1; sreg 01->8E->47->AD; cap=8'h0B after 4th bit_stb.
//  2 run=1 for 255*6 clks -> exactly 255 bit_stb, one frame_stb on 255th, sreg back to 8'h01; no state repeats before.
//  3 man_en=1, DIV=6 -> chip 1 gives m_man 0,0,0,1,1,1; chip 0 gives 1,1,1,0,0,0; IDLE gives m_man=0.
//  4 run=1, drop run at cnt=2 -> 3 more clks, bit_stb on cnt=5, then IDLE, sreg frozen; re-raise run in DRAIN -> no stop.
//  5 seed_ld seed_in=8'h00 -> sreg=8'h01, seed_err=1 sticky until nCR; seed_ld 8'hA5 -> frame_stb 255 chips later at sreg=A5.
//  6 nCR=0 mid-chip in RUN with seed_ld=1 same cycle -> reset values win, state IDLE, cnt=0, seed_err=0.

Source files
------------

// File: rtl/mseq_gen_ch_pkg.sv
// Shared definitions for the m-sequence chip generator and its BER checker peer.
// Generator FSM encoding plus the standard primitive feedback polynomials.
package mseq_gen_ch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Polynomials include both the x^W and x^0 terms
  localparam logic [8:0]  POLY8  = 9'h11D;
  localparam logic [12:0] POLY12 = 13'h1053;
  localparam logic [16:0] POLY16 = 17'h1100B;

endpackage

// File: rtl/mseq_gen_ch_lfsr_core.sv
// Galois right-shift LFSR next-state function; purely combinational.
// The owner of the state register decides when to apply it.
module mseq_gen_ch_lfsr_core
  import mseq_gen_ch_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W:0]     POLY = POLY8
) (
  input  logic [W-1:0] sreg,
  output logic [W-1:0] next_sreg
);

  localparam logic [W-1:0] TAPS = POLY[W:1];

  assign next_sreg = sreg[0] ? ((sreg >> 1) ^ TAPS) : (sreg >> 1);

endmodule

// File: rtl/mseq_gen_ch.sv
// PN chip generator: clock divider, run/stop FSM, seed load with zero protection,
// period strobe, chip-history capture and optional Manchester line coding.
module mseq_gen_ch
  import mseq_gen_ch_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W:0]   POLY = POLY8,
  parameter logic [W-1:0] SEED = 1,
  parameter int           DIV  = 6,
  parameter int           CAP  = 8
) (
  input  logic           clk,
  input  logic           nCR,
  input  logic           run,
  input  logic           seed_ld,
  input  logic [W-1:0]   seed_in,
  input  logic           man_en,
  output logic           m,
  output logic           m_man,
  output logic           bit_stb,
  output logic           frame_stb,
  output logic [W-1:0]   sreg,
  output logic [CAP-1:0] cap,
  output logic           seed_err
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   seed_reg;
  logic [W-1:0]   next_sreg;
  logic [CAP:0]   cap_shift;

  mseq_gen_ch_lfsr_core #(.W(W), .POLY(POLY)) u_core (
    .sreg      (sreg),
    .next_sreg (next_sreg)
  );

  assign m         = sreg[0];
  assign cap_shift = {cap, sreg[0]};

  always_ff @(posedge clk) begin
    if (!nCR) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_stb   = 1'b0;
    frame_stb = 1'b0;
    m_man     = 1'b0;

    // A seed load restarts the chip, so it suppresses the strobe of the chip it cuts short
    if (state != ST_IDLE && cnt == CNT_LAST && !seed_ld) bit_stb = 1'b1;
    frame_stb = bit_stb && (next_sreg == seed_reg);

    if (state != ST_IDLE) begin
      if (man_en) m_man = (cnt >= CNT_HALF) ? sreg[0] : ~sreg[0];
      else        m_man = sreg[0];
    end

    case (state)
      ST_IDLE:  if (run) state_nxt = ST_RUN;
      ST_RUN:   if (!seed_ld && !run) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (seed_ld)      state_nxt = ST_IDLE;
        else if (run)     state_nxt = ST_RUN;
        else if (bit_stb) state_nxt = ST_IDLE;
      end
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nCR) begin
      sreg     <= SEED;
      seed_reg <= SEED;
      cnt      <= '0;
      cap      <= '0;
      seed_err <= 1'b0;
    end else if (seed_ld) begin
      cnt <= '0;
      if (seed_in != '0) begin
        sreg     <= seed_in;
        seed_reg <= seed_in;
      end else begin
        // An all-zero state would lock the LFSR; fall back and flag it
        sreg     <= SEED;
        seed_reg <= SEED;
        seed_err <= 1'b1;
      end
    end else begin
      if (state == ST_IDLE)     cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
      if (bit_stb) begin
        sreg <= next_sreg;
        cap  <= cap_shift[CAP-1:0];
      end
    end
  end

endmodule
